// File: rtl/seg7_diff_display.sv
// seg7_diff_display
//   Display stage for a 3-bit ripple borrow subtractor. A load strobe
//   snapshots the operands and the subtractor result; the result is shown
//   as sign + magnitude on a time-multiplexed 4-digit common-anode display.
//   Digit layout: an[3] = A, an[2] = B (dp lit when borrow-in set),
//   an[1] = sign (dash when negative), an[0] = |A - B - Cin|.
//
//   Handshake: load is a plain 1-cycle strobe with no back-pressure; every
//   cycle it is high (and rst_n is high) the inputs are captured, so the
//   last of several back-to-back loads wins.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset
//   load   in   1  capture strobe for a, b, cin, r, bout
//   a      in   3  minuend
//   b      in   3  subtrahend
//   cin    in   1  borrow-in
//   r      in   3  difference (a - b - cin) mod 8
//   bout   in   1  borrow-out, 1 = negative result
//   an     out  4  digit enables, active-low
//   seg    out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp     out  1  decimal point, active-low
module seg7_diff_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  input  logic [2:0] r,
  input  logic       bout,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_e;

  scan_e         state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  logic          valid_q, valid_d;
  logic [2:0]    a_q, a_d;
  logic [2:0]    b_q, b_d;
  logic          cin_q, cin_d;
  logic [2:0]    r_q, r_d;
  logic          bout_q, bout_d;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [3:0]    mag;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A negative result r is the two's-complement wrap of -(8 - r), so the
  // magnitude is 8 - r; the single case r=0 with borrow gives 8.
  assign mag = bout_q ? (4'd8 - {1'b0, r_q}) : {1'b0, r_q};

  always_comb begin
    wrap    = (cnt_q == LAST);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;

    state_d = state_q;
    if (wrap) begin
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        default: state_d = DIG0;
      endcase
    end

    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    r_d     = r_q;
    bout_d  = bout_q;
    if (load) begin
      valid_d = 1'b1;
      a_d     = a;
      b_d     = b;
      cin_d   = cin;
      r_d     = r;
      bout_d  = bout;
    end

    // Outputs come from the current (pre-edge) index and snapshot, so a
    // load and a wrap on the same edge appear together one cycle later.
    an_d  = 4'b1111;
    seg_d = SEG_DASH;
    dp_d  = 1'b1;
    case (state_q)
      DIG0: begin
        an_d = 4'b1110;
        if (valid_q) seg_d = hex_font(mag);
      end
      DIG1: begin
        an_d = 4'b1101;
        if (valid_q) seg_d = bout_q ? SEG_DASH : SEG_BLANK;
      end
      DIG2: begin
        an_d = 4'b1011;
        if (valid_q) begin
          seg_d = hex_font({1'b0, b_q});
          dp_d  = ~cin_q;
        end
      end
      default: begin
        an_d = 4'b0111;
        if (valid_q) seg_d = hex_font({1'b0, a_q});
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DIG0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      r_q     <= '0;
      bout_q  <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      r_q     <= r_d;
      bout_q  <= bout_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_diff_display.sv
// tb_seg7_diff_display
//   Bench for seg7_diff_display with a 4-cycle digit period. The reference
//   model counts edges since reset and derives the scanned digit and its
//   content from the signed value a - b - cin with plain arithmetic.
module tb_seg7_diff_display;

  localparam int DIV = 4;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [2:0] a;
  logic [2:0] b;
  logic       cin;
  logic [2:0] r;
  logic       bout;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int compared   = 0;
  int mismatched = 0;

  seg7_diff_display #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .r     (r),
    .bout  (bout),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [6:0] font_tab [9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000};

  int         k;        // edges since the last reset edge
  logic       m_valid;
  int         m_a, m_b, m_cin;
  int         m_idx, m_diff;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0; m_valid = 0; m_a = 0; m_b = 0; m_cin = 0;
      exp_an = 4'b1111; exp_seg = BLANK; exp_dp = 1'b1;
    end else begin
      k++;
      m_idx  = ((k - 1) / DIV) % 4;
      m_diff = m_a - m_b - m_cin;
      exp_an = 4'b1111;
      exp_an[m_idx] = 1'b0;
      exp_dp = 1'b1;
      if (!m_valid) exp_seg = DASH;
      else begin
        case (m_idx)
          3: exp_seg = font_tab[m_a];
          2: begin exp_seg = font_tab[m_b]; exp_dp = (m_cin == 0); end
          1: exp_seg = (m_diff < 0) ? DASH : BLANK;
          default: exp_seg = font_tab[(m_diff < 0) ? -m_diff : m_diff];
        endcase
      end
      if (load) begin
        m_valid = 1'b1; m_a = int'(a); m_b = int'(b); m_cin = int'(cin);
      end
    end
  end

  // ---------------- driver ----------------
  // The subtractor result is produced the way the upstream block would.
  task automatic drive_load(input int va, input int vb, input int vc);
    int d;
    d    = va - vb - vc;
    a    = 3'(va);
    b    = 3'(vb);
    cin  = 1'(vc);
    r    = 3'(d & 7);
    bout = (d < 0);
    load = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] e_an;
    rst_n = 1'b0; load = 1'b0; a = '0; b = '0; cin = 1'b0; r = '0; bout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if ({an, seg, dp} !== {4'b1111, BLANK, 1'b1}) begin
        mismatched++;
        $display("FAIL reset_hold[%0d]: got an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1",
                 i, an, seg, dp);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e_an = 4'b1111;
      e_an[i / 4] = 1'b0;
      compared++;
      if ({an, seg, dp} !== {e_an, DASH, 1'b1}) begin
        mismatched++;
        $display("FAIL reset_scan[%0d]: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                 i, an, seg, dp, e_an, DASH);
      end
    end
  endtask

  task automatic test_digits();
    int         va [3]   = '{5, 2, 0};
    int         vb [3]   = '{2, 5, 7};
    int         vc [3]   = '{0, 0, 1};
    logic [6:0] d0 [3]   = '{7'b0110000, 7'b0110000, 7'b0000000};
    logic [6:0] d1 [3]   = '{BLANK, DASH, DASH};
    for (int v = 0; v < 3; v++) begin
      drive_load(va[v], vb[v], vc[v]);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        load = 1'b0;
        compared++;
        if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
          mismatched++;
          $display("FAIL digits[%0d] cyc %0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                   v, c, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
        if (c >= 1 && an === 4'b1110) begin
          compared++;
          if (seg !== d0[v]) begin
            mismatched++;
            $display("FAIL digits[%0d] magnitude: got seg=%b, expected seg=%b", v, seg, d0[v]);
          end
        end
        if (c >= 1 && an === 4'b1101) begin
          compared++;
          if (seg !== d1[v]) begin
            mismatched++;
            $display("FAIL digits[%0d] sign: got seg=%b, expected seg=%b", v, seg, d1[v]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        load = 1'b0;
        compared++;
        if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
          mismatched++;
          $display("FAIL random idle n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                   n, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
      end
      drive_load($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
      @(negedge clk);
      load = 1'b0;
      compared++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        mismatched++;
        $display("FAIL random load n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Three consecutive loads; only the last must be displayed.
    drive_load(1, 6, 0);
    @(negedge clk);
    drive_load(6, 1, 1);
    @(negedge clk);
    drive_load(0, 7, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      load = 1'b0;
      compared++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        mismatched++;
        $display("FAIL back_to_back cyc %0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 c, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_wrap_load();
    logic [3:0] prev_an;
    int         run;
    bit         seen_change;
    prev_an = an; run = 0; seen_change = 0;
    for (int c = 0; c < 48; c++) begin
      // k+1 is the number of the coming edge; multiples of DIV are wrap edges.
      if ((k + 1) % DIV == 0 || (k + 1) % DIV == 2)
        drive_load($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
      @(negedge clk);
      load = 1'b0;
      compared++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        mismatched++;
        $display("FAIL wrap_load cyc %0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 c, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (an !== prev_an) begin
        if (seen_change) begin
          compared++;
          if (run != DIV) begin
            mismatched++;
            $display("FAIL digit_period: got %0d cycles, expected %0d", run, DIV);
          end
        end
        seen_change = 1;
        run = 1;
        prev_an = an;
      end else begin
        run++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    logic [3:0] e_an;
    drive_load(3, 4, 1);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (c >= 1 && an === 4'b1011) found = 1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL reset_mid wait: got no an=1011 within 40 cycles, expected digit 2 to be scanned");
    end
    compared++;
    if (seg !== font_tab[4] || dp !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid pre: got seg=%b dp=%b, expected seg=%b dp=0", seg, dp, font_tab[4]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    compared++;
    if ({an, seg, dp} !== {4'b1111, BLANK, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_mid blank: got an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1",
               an, seg, dp);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e_an = 4'b1111;
      e_an[i / 4] = 1'b0;
      compared++;
      if ({an, seg, dp} !== {e_an, DASH, 1'b1}) begin
        mismatched++;
        $display("FAIL reset_mid restart[%0d]: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                 i, an, seg, dp, e_an, DASH);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_digits();
    test_random();
    test_back_to_back();
    test_wrap_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
